// File: rtl/auth_resp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : auth_resp_arbiter_pkg
//  Description : Shared constants, state encoding and helper function for the
//                authentication responder arbiter. The message-field codes
//                are the ones used elsewhere in the authentication fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
package auth_resp_arbiter_pkg;

    // Default message width. The header occupies the top 32 bits.
    localparam int MSG_LEN_DEFAULT = 64;

    // Header field codes used when the arbiter synthesizes an ERROR reply.
    localparam logic [7:0] AUTH_PROTOCOL_VER    = 8'h01;
    localparam logic [7:0] AUTH_MSG_ERROR       = 8'h7F;
    localparam logic [7:0] AUTH_ERR_UNSPECIFIED = 8'h04;

    // One-hot state encoding for the arbiter FSM.
    localparam int SIZE_OF_STATES_ARB = 5;

    typedef enum logic [SIZE_OF_STATES_ARB-1:0] {
        ST_IDLE     = 5'b00001,
        ST_WAIT_RSP = 5'b00010,
        ST_ACK      = 5'b00100,
        ST_DELIVER  = 5'b01000,
        ST_ERR      = 5'b10000
    } arb_state_e;

    // Header of the ERROR reply: version, ERROR type, Unspecified, Param2 = 0.
    function automatic logic [31:0] auth_err_header();
        return {AUTH_PROTOCOL_VER, AUTH_MSG_ERROR, AUTH_ERR_UNSPECIFIED, 8'h00};
    endfunction

endpackage : auth_resp_arbiter_pkg
`default_nettype wire

// File: rtl/auth_resp_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : auth_resp_arbiter_rr_pick
//  Description : Combinational round-robin priority picker. Searches upward
//                from last_grant+1 (wrapping modulo NUM_REQ) and returns the
//                first requester found as a one-hot grant; all-zero when no
//                request is pending.
//  Ports       : req_valid  [NUM_REQ-1:0] - pending requests
//                last_grant [IDX_W-1:0]   - index of the previous winner
//                grant      [NUM_REQ-1:0] - one-hot winner
//  Revision    : 1.0 - initial release
// ============================================================================
module auth_resp_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Offset k = 1 is checked first so the previous winner has lowest
    // priority; k = NUM_REQ wraps back to the previous winner itself.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule : auth_resp_arbiter_rr_pick
`default_nettype wire

// File: rtl/auth_resp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : auth_resp_arbiter
//  Description : Shares one authentication responder between NUM_REQ
//                requesters. Grants round-robin, presents the winner's
//                message to the responder, captures the reply, completes the
//                Ack_in handshake and returns the reply to the winner. A
//                stalled responder is timed out: an ERROR reply is returned
//                and a responder flush is requested.
//  Ports       : clk, reset (sync, active-low)
//                req_valid/req_msg/req_ready      - requester request side
//                rsp_valid/rsp_msg/rsp_ack        - requester response side
//                resp_req_in/auth_msg_resp_in     - request to the responder
//                resp_req_out/auth_msg_resp_out   - reply from the responder
//                Ack_in                           - reply accepted
//                resp_flush, timeout_err, busy    - status / control
//  Revision    : 1.0 - initial release
// ============================================================================
module auth_resp_arbiter
    import auth_resp_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int MSG_LEN        = MSG_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*MSG_LEN-1:0] req_msg,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [MSG_LEN-1:0]         rsp_msg,
    input  logic [NUM_REQ-1:0]         rsp_ack,
    output logic                       resp_req_in,
    output logic [MSG_LEN-1:0]         auth_msg_resp_in,
    input  logic                       resp_req_out,
    input  logic [MSG_LEN-1:0]         auth_msg_resp_out,
    output logic                       Ack_in,
    output logic                       resp_flush,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [MSG_LEN-1:0]  msg_q, msg_d;
    logic [MSG_LEN-1:0]  rsp_msg_q, rsp_msg_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [MSG_LEN-1:0]  err_msg;
    logic [NUM_REQ-1:0]  owner_onehot;

    auth_resp_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // One-hot grant to index, used to select the winner's message slice.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Synthesized ERROR reply: fixed header, zero payload.
    always_comb begin
        err_msg                 = '0;
        err_msg[MSG_LEN-1 -: 32] = auth_err_header();
    end

    // owner_d only changes on the IDLE grant, so in every state that can lead
    // to DELIVER it equals owner_q.
    assign owner_onehot = NUM_REQ'(1) << owner_d;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        rsp_msg_d    = rsp_msg_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        resp_req_in  = 1'b0;
        Ack_in       = 1'b0;
        resp_flush   = 1'b0;
        timeout_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    // reset gates the strobe so nothing looks accepted while
                    // the synchronous reset is being applied.
                    req_ready = grant & {NUM_REQ{reset}};
                    msg_d     = req_msg[int'(grant_idx)*MSG_LEN +: MSG_LEN];
                    owner_d   = grant_idx;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_RSP;
                end
            end

            ST_WAIT_RSP: begin
                resp_req_in = 1'b1;
                // A reply on the terminal-count cycle still wins.
                if (resp_req_out) begin
                    rsp_msg_d = auth_msg_resp_out;
                    cnt_d     = '0;
                    state_d   = ST_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ACK: begin
                Ack_in = 1'b1;
                if (!resp_req_out) begin
                    state_d = ST_DELIVER;
                end else if (cnt_q == CNT_LAST) begin
                    // Responder never released its valid: deliver the reply
                    // already captured and have the system flush it.
                    resp_flush = 1'b1;
                    state_d    = ST_DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ERR: begin
                rsp_msg_d   = err_msg;
                resp_flush  = 1'b1;
                timeout_err = 1'b1;
                state_d     = ST_DELIVER;
            end

            ST_DELIVER: begin
                // Only the owner's acknowledge closes the transaction.
                if (rsp_ack[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_DELIVER) ? owner_onehot : '0;
    end

    // ------------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            msg_q        <= '0;
            rsp_msg_q    <= '0;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            rsp_msg_q    <= rsp_msg_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_msg          = rsp_msg_q;
    assign auth_msg_resp_in = msg_q;
    assign busy             = (state_q != ST_IDLE);

endmodule : auth_resp_arbiter
`default_nettype wire

// File: tb/tb_auth_resp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_auth_resp_arbiter
//  Description : Self-checking bench for auth_resp_arbiter. Requesters keep a
//                pending mask; the expected winner, message and reply come
//                from a transaction-level round-robin model. Directed cases
//                cover the listed scenarios, followed by random transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_auth_resp_arbiter;

    localparam int NR = 2;
    localparam int ML = 64;
    localparam int T  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*ML-1:0]  req_msg;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [ML-1:0]     rsp_msg;
    logic [NR-1:0]     rsp_ack;
    logic              resp_req_in;
    logic [ML-1:0]     auth_msg_resp_in;
    logic              resp_req_out;
    logic [ML-1:0]     auth_msg_resp_out;
    logic              Ack_in;
    logic              resp_flush;
    logic              timeout_err;
    logic              busy;

    auth_resp_arbiter #(
        .NUM_REQ        (NR),
        .MSG_LEN        (ML),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_msg           (req_msg),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_msg           (rsp_msg),
        .rsp_ack           (rsp_ack),
        .resp_req_in       (resp_req_in),
        .auth_msg_resp_in  (auth_msg_resp_in),
        .resp_req_out      (resp_req_out),
        .auth_msg_resp_out (auth_msg_resp_out),
        .Ack_in            (Ack_in),
        .resp_flush        (resp_flush),
        .timeout_err       (timeout_err),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            mdl_last;
    logic [NR-1:0] pend;
    logic [ML-1:0] msgs [NR];
    int            grants[$];

    localparam logic [ML-1:0] ERR_MSG = {32'h017F_0400, 32'h0};

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NR-1:0] oh(input int w);
        logic [NR-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Next winner: first pending requester after the previous winner.
    function automatic int mdl_pick(input logic [NR-1:0] v);
        int idx;
        for (int k = 1; k <= NR; k++) begin
            idx = (mdl_last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive_req();
        req_valid = pend;
        for (int i = 0; i < NR; i++) req_msg[i*ML +: ML] = msgs[i];
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        req_valid = '1;
        tick();
        tick();
        check_val("rst_ready", 64'(req_ready), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_val("rst_rsp_msg", 64'(rsp_msg), 64'(0));
        check_val("rst_req_in", 64'(resp_req_in), 64'(0));
        check_val("rst_msg_in", 64'(auth_msg_resp_in), 64'(0));
        check_val("rst_ack_in", 64'(Ack_in), 64'(0));
        check_val("rst_flush", 64'(resp_flush), 64'(0));
        check_val("rst_terr", 64'(timeout_err), 64'(0));
        reset     = 1'b1;
        req_valid = '0;
        mdl_last  = NR - 1;
        pend      = '0;
    endtask

    // One arbitrated transaction starting at a negedge with the DUT idle.
    //   d  : reply delay in WAIT_RSP cycles (-1: responder silent)
    //   h  : extra ACK cycles the responder holds its valid (-1: never drops)
    task automatic do_txn(input logic [NR-1:0] add, input bit rand_msgs, input int gap,
                          input int d, input int h, input int kwait,
                          input bit other_ack, input bit abort_ack);
        int            w;
        logic [ML-1:0] exp_req, reply, exp_rsp;
        bit            timed_out, left;

        req_valid = '0;
        for (int g = 0; g < gap; g++) begin
            #1;
            check_val("gap_ready", 64'(req_ready), 64'(0));
            check_val("gap_busy", 64'(busy), 64'(0));
            tick();
        end

        pend = pend | add;
        if (pend == '0) pend = oh($urandom_range(NR - 1, 0));
        if (rand_msgs) for (int i = 0; i < NR; i++) msgs[i] = {$urandom, $urandom};
        drive_req();
        w       = mdl_pick(pend);
        exp_req = msgs[w];
        grants.push_back(w);
        #1;
        check_val("grant_ready", 64'(req_ready), 64'(oh(w)));
        check_val("idle_busy", 64'(busy), 64'(0));
        tick();

        pend[w]   = 1'b0;
        req_valid = pend;
        reply     = {$urandom, $urandom};
        timed_out = 1'b1;
        check_val("wait_ready", 64'(req_ready), 64'(0));

        for (int c = 0; c < T; c++) begin
            check_val("wait_req_in", 64'(resp_req_in), 64'(1));
            check_val("wait_msg_in", 64'(auth_msg_resp_in), 64'(exp_req));
            check_val("wait_terr", 64'(timeout_err), 64'(0));
            check_val("wait_busy", 64'(busy), 64'(1));
            if (c == d) begin
                resp_req_out      = 1'b1;
                auth_msg_resp_out = reply;
            end
            tick();
            if (c == d) begin
                timed_out = 1'b0;
                break;
            end
        end

        if (timed_out) begin
            check_val("err_terr", 64'(timeout_err), 64'(1));
            check_val("err_flush", 64'(resp_flush), 64'(1));
            check_val("err_req_in", 64'(resp_req_in), 64'(0));
            exp_rsp = ERR_MSG;
            tick();
        end else begin
            left = 1'b0;
            for (int j = 0; j < T && !left; j++) begin
                check_val("ack_in", 64'(Ack_in), 64'(1));
                check_val("ack_req_in", 64'(resp_req_in), 64'(0));
                check_val("ack_terr", 64'(timeout_err), 64'(0));
                if (abort_ack) begin
                    reset     = 1'b0;
                    pend[w]   = 1'b1;
                    req_valid = pend;
                    tick();
                    check_val("abort_req_in", 64'(resp_req_in), 64'(0));
                    check_val("abort_ack_in", 64'(Ack_in), 64'(0));
                    check_val("abort_rsp_valid", 64'(rsp_valid), 64'(0));
                    check_val("abort_rsp_msg", 64'(rsp_msg), 64'(0));
                    check_val("abort_msg_in", 64'(auth_msg_resp_in), 64'(0));
                    check_val("abort_busy", 64'(busy), 64'(0));
                    check_val("abort_ready", 64'(req_ready), 64'(0));
                    check_val("abort_flush", 64'(resp_flush), 64'(0));
                    check_val("abort_terr", 64'(timeout_err), 64'(0));
                    reset        = 1'b1;
                    req_valid    = '0;
                    resp_req_out = 1'b0;
                    mdl_last     = NR - 1;
                    return;
                end
                if (j == h) resp_req_out = 1'b0;
                #1;
                check_val("ack_flush", 64'(resp_flush), 64'((j == T - 1) && (j != h)));
                tick();
                if (j == h) left = 1'b1;
            end
            resp_req_out = 1'b0;
            exp_rsp      = reply;
        end

        for (int k = 0; k <= kwait; k++) begin
            check_val("dlv_valid", 64'(rsp_valid), 64'(oh(w)));
            check_val("dlv_msg", 64'(rsp_msg), 64'(exp_rsp));
            check_val("dlv_ack_in", 64'(Ack_in), 64'(0));
            check_val("dlv_flush", 64'(resp_flush), 64'(0));
            check_val("dlv_busy", 64'(busy), 64'(1));
            if (k < kwait) rsp_ack = other_ack ? ~oh(w) : '0;
            else           rsp_ack = oh(w);
            tick();
        end
        rsp_ack  = '0;
        mdl_last = w;
        check_val("done_valid", 64'(rsp_valid), 64'(0));
        check_val("done_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int r, d, h;

        reset             = 1'b0;
        req_valid         = '0;
        req_msg           = '0;
        rsp_ack           = '0;
        resp_req_out      = 1'b0;
        auth_msg_resp_out = '0;
        mdl_last          = NR - 1;
        pend              = '0;
        for (int i = 0; i < NR; i++) msgs[i] = '0;
        @(negedge clk);
        apply_reset();

        // Single request from req0, reply after 5 cycles, 2-cycle ack hold.
        msgs[0] = {32'h0181_0000, $urandom};
        msgs[1] = {$urandom, $urandom};
        do_txn(2'b01, 1'b0, 0, 5, 2, 1, 1'b0, 1'b0);

        // Both requesting continuously: order must be 0,1,0,1.
        apply_reset();
        grants.delete();
        for (int n = 0; n < 4; n++) do_txn(2'b11, 1'b1, 0, n + 1, 0, 0, 1'b0, 1'b0);
        check_val("order0", 64'(grants[0]), 64'(0));
        check_val("order1", 64'(grants[1]), 64'(1));
        check_val("order2", 64'(grants[2]), 64'(0));
        check_val("order3", 64'(grants[3]), 64'(1));

        // Silent responder, then a reply on the terminal-count cycle.
        do_txn(2'b00, 1'b1, 1, -1, 0, 0, 1'b0, 1'b0);
        do_txn(2'b00, 1'b1, 0, T - 1, 0, 0, 1'b0, 1'b0);
        // Responder never drops its valid in ACK.
        do_txn(2'b00, 1'b1, 0, 2, -1, 0, 1'b0, 1'b0);

        // Non-owner acknowledge during DELIVER must not end the transaction.
        apply_reset();
        do_txn(2'b01, 1'b1, 0, 1, 0, 3, 1'b1, 1'b0);
        // Reset during ACK; the following grant goes to req0.
        do_txn(2'b10, 1'b1, 0, 1, 0, 0, 1'b0, 1'b1);
        do_txn(2'b01, 1'b1, 0, 3, 1, 0, 1'b0, 1'b0);
        check_val("post_reset_grant", 64'(grants[grants.size() - 1]), 64'(0));

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(15, 0);
            d = (r == 0) ? -1 : ((r == 1) ? T - 1 : $urandom_range(7, 0));
            r = $urandom_range(15, 0);
            h = (r == 0) ? -1 : $urandom_range(2, 0);
            do_txn(NR'($urandom), 1'b1, $urandom_range(2, 0), d, h,
                   $urandom_range(3, 0), 1'($urandom), ($urandom_range(19, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_auth_resp_arbiter
`default_nettype wire

// File: doc/auth_resp_arbiter.md
# auth_resp_arbiter

- Shares one authentication `responder` between `NUM_REQ` requesters (PD-side initiators).
- Arbitrates round-robin, holds the winner's request on `resp_req_in`/`auth_msg_resp_in`, captures the responder's reply, completes the `Ack_in` handshake and returns the reply to the winner.
- Times out a stalled responder, returns a synthesized ERROR message and requests a responder flush.
- Sits between the requester fabric and the responder instance.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `MSG_LEN`, `` `MSG_LEN ``: message width, header in the top 32 bits.
- `TIMEOUT_CYCLES`, 256: cycle budget in WAIT_RSP and in ACK (≥4).

Ports (clock and reset first):
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: **synchronous, active-low** (0 = reset).
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_msg` in NUM_REQ*MSG_LEN: request messages; requester i at slice [i*MSG_LEN +: MSG_LEN].
- `req_ready` out NUM_REQ: one-hot, combinational; high in IDLE for the granted requester.
- `rsp_valid` out NUM_REQ: one-hot, registered; response available.
- `rsp_msg` out MSG_LEN: registered response, shared by all requesters.
- `rsp_ack` in NUM_REQ: requester consumed the response.
- `resp_req_in` out 1: request strobe to the responder.
- `auth_msg_resp_in` out MSG_LEN: message to the responder.
- `resp_req_out` in 1: responder reply valid.
- `auth_msg_resp_out` in MSG_LEN: responder reply.
- `Ack_in` out 1: reply accepted, to the responder.
- `resp_flush` out 1: one-cycle pulse; system resets the responder.
- `timeout_err` out 1: one-cycle pulse on timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, WAIT_RSP, ACK, DELIVER, ERR.
- **IDLE:** if `req_valid` != 0, winner w = first set bit searching upward from `last_grant+1` (mod NUM_REQ).
  - `req_ready[w]`=1 that cycle.
  - At the edge: `msg_q` <= slice w, `owner` <= w, counter <= 0, go WAIT_RSP.
- **WAIT_RSP:** `resp_req_in`=1, `auth_msg_resp_in`=`msg_q` held stable; counter +1 per cycle.
  - `resp_req_out`=1: `rsp_msg` <= `auth_msg_resp_out`, counter <= 0, go ACK.
  - Otherwise, counter == TIMEOUT_CYCLES-1: go ERR.
- **ACK:** `resp_req_in`=0, `Ack_in`=1.
  - `resp_req_out`=0 seen: go DELIVER.
  - Otherwise, counter == TIMEOUT_CYCLES-1: pulse `resp_flush`, go DELIVER with the captured reply.
- **ERR:** `rsp_msg` <= {ProtocolVersion 8'h01, MessageType 8'h7F (ERROR), Param1 8'h04 (Unspecified), Param2 8'h00, payload 0}.
  - Pulse `resp_flush` and `timeout_err`.
  - `resp_req_in`=0, go DELIVER.
- **DELIVER:** `rsp_valid[owner]`=1 until `rsp_ack[owner]`=1 sampled.
  - Then `last_grant` <= `owner`, go IDLE.
  - `rsp_ack` bits of other requesters are ignored.
- Boundary rules:
  - Response and timeout in the same cycle: the response wins.
  - `req_valid` dropped before grant: no capture.
  - `req_valid` of a non-owner during service is held off and not lost.
  - A requester re-requesting while its response is undelivered is impossible: `req_ready` only occurs in IDLE.
  - All-ones or all-zero `req_valid` patterns follow the same rotation.
- Reset mid-operation (`reset`=0 at any edge):
  - State IDLE, counter 0, `last_grant` = NUM_REQ-1 (requester 0 wins first).
  - `rsp_msg`=0, `msg_q`=0; the in-flight request is dropped and the requester must reissue.

## Timing
- Reset values: `resp_req_in`, `Ack_in`, `rsp_valid`, `resp_flush`, `timeout_err` = 0; `busy`=0; `rsp_msg`=0; `auth_msg_resp_in`=0; `req_ready`=0 while `reset`=0.
- Grant to `resp_req_in`=1: 1 cycle.
- `resp_req_out` rise to `Ack_in`=1: 1 cycle.
- `resp_req_out` fall to `rsp_valid`=1: 1 cycle.
- `rsp_ack` to IDLE: 1 cycle; new grant possible in that IDLE cycle.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entering WAIT_RSP. `timeout_err` and `resp_flush` assert in the ERR cycle; `rsp_valid` asserts the next cycle.
- The responder drives outputs on negedge; its reply is sampled here on posedge only.

## Structure
- Shared `Parameters.v` gains: `AUTH_PROTOCOL_VER` (8'h01), `AUTH_MSG_ERROR` (8'h7F), `AUTH_ERR_UNSPECIFIED` (8'h04), `SIZE_OF_STATES_ARB`, and the one-hot state encodings.
- One sub-module, `rr_pick`: combinational round-robin priority picker, inputs `req_valid` and `last_grant`, output a one-hot grant.

## Test plan
- Single request, NUM_REQ=2: req0 msg header 0x01_81_00_00, responder replies after 5 cycles → `rsp_msg` equals the reply, `rsp_valid`=2'b01, `Ack_in` high until `resp_req_out` drops.
- Both valid continuously, 4 transactions → grant order 0,1,0,1; no starvation.
- Responder silent → `timeout_err` pulse exactly 256 cycles after WAIT_RSP entry; `rsp_msg` header 0x01_7F_04_00; `resp_flush`=1 for one cycle.
- `resp_req_out` rises on the terminal-count cycle → normal reply delivered, no `timeout_err`.
- `reset`=0 during ACK → next cycle all outputs 0, `busy`=0; the following grant goes to req0.
- `rsp_ack[1]` asserted while owner is 0 → `rsp_valid` held until `rsp_ack[0]`.
